// File: rtl/rf_pkg.sv
// Shared parameters and FSM state encoding for the register-file burst sequencer.
package rf_pkg;
  localparam int RF_AW    = 3;
  localparam int RF_DW    = 8;
  localparam int RF_DEPTH = 1 << RF_AW;
  localparam int RF_CW    = 4;

  typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_OUT, DONE} state_t;
endpackage

// File: rtl/rf_seq_ctrl_if.sv
// Write-stream and read-stream bundle between a byte source/sink and the sequencer.
// A beat moves on any posedge where valid && ready; the valid side keeps data and valid
// stable until that edge, and ready may change freely.
interface rf_seq_ctrl_if #(parameter int DW = 8);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (output in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_valid);
  modport slave  (input  in_data, in_valid, out_ready,
                  output in_ready, out_data, out_valid);
endinterface

// File: rtl/reg8.sv
// 8x8 register file: write on negedge when wen, combinational read on addr.
module reg8
  import rf_pkg::*;
(
  input  logic             clk,
  input  logic [RF_AW-1:0] addr,
  input  logic [RF_DW-1:0] din,
  input  logic             wen,
  output logic [RF_DW-1:0] dout
);
  logic [RF_DW-1:0] mem [RF_DEPTH];

  always_ff @(negedge clk) begin
    if (wen) mem[addr] <= din;
  end

  assign dout = mem[addr];
endmodule

// File: rtl/rf_addr_cnt.sv
// Loadable wrap-around address counter with a clamped remaining-entries down-counter.
module rf_addr_cnt #(
  parameter int AW = 3,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] base,
  input  logic [CW-1:0] len,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic          last
);
  localparam logic [CW-1:0] DEPTH = CW'(1 << AW);

  logic [CW-1:0] remaining;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= base;
      remaining <= (len > DEPTH) ? DEPTH : len;
    end else if (step) begin
      addr      <= addr + AW'(1);
      remaining <= remaining - CW'(1);
    end
  end

  assign last = (remaining == CW'(1));
endmodule

// File: rtl/rf_seq_ctrl.sv
// Burst sequencer in front of reg8: streams bytes into consecutive RF entries or
// scans consecutive entries out as a byte stream. Every output is registered.
module rf_seq_ctrl
  import rf_pkg::*;
#(
  parameter int AW = RF_AW,
  parameter int DW = RF_DW,
  parameter int CW = RF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_wr,
  input  logic          start_rd,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] count,
  rf_seq_ctrl_if.slave  strm,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_din,
  output logic          rf_wen,
  input  logic [DW-1:0] rf_dout,
  output state_t        fsm_state
);
  state_t        state, state_nx;
  logic          in_ready_q, in_ready_nx;
  logic          out_valid_q, out_valid_nx;
  logic [DW-1:0] out_data_q, out_data_nx;
  logic [AW-1:0] rf_addr_q, rf_addr_nx;
  logic [DW-1:0] rf_din_q, rf_din_nx;
  logic          rf_wen_q, rf_wen_nx;
  logic          busy_q, done_q;
  logic          cnt_load, cnt_step, cnt_last;
  logic [AW-1:0] cur_addr, next_addr;
  logic          wr_hs, rd_hs;

  rf_addr_cnt #(.AW(AW), .CW(CW)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .base  (base_addr),
    .len   (count),
    .step  (cnt_step),
    .addr  (cur_addr),
    .last  (cnt_last)
  );

  assign next_addr = cur_addr + AW'(1);
  assign wr_hs     = (state == WRITE) && strm.in_valid && in_ready_q;
  assign rd_hs     = (state == RD_OUT) && out_valid_q && strm.out_ready;

  always_comb begin
    state_nx     = state;
    in_ready_nx  = in_ready_q;
    out_valid_nx = out_valid_q;
    out_data_nx  = out_data_q;
    rf_addr_nx   = rf_addr_q;
    rf_din_nx    = rf_din_q;
    rf_wen_nx    = 1'b0;
    cnt_load     = 1'b0;
    cnt_step     = 1'b0;
    case (state)
      IDLE: begin
        if (start_wr) begin
          cnt_load = 1'b1;
          if (count == '0) begin
            state_nx = DONE;
          end else begin
            state_nx    = WRITE;
            in_ready_nx = 1'b1;
          end
        end else if (start_rd) begin
          cnt_load = 1'b1;
          if (count == '0) begin
            state_nx = DONE;
          end else begin
            state_nx   = RD_ADDR;
            rf_addr_nx = base_addr;
          end
        end
      end
      WRITE: begin
        if (wr_hs) begin
          rf_wen_nx  = 1'b1;
          rf_din_nx  = strm.in_data;
          rf_addr_nx = cur_addr;
          cnt_step   = 1'b1;
          if (cnt_last) begin
            in_ready_nx = 1'b0;
            state_nx    = DONE;
          end
        end
      end
      // rf_addr already points at the entry during this cycle, so rf_dout is settled.
      RD_ADDR: begin
        out_data_nx  = rf_dout;
        out_valid_nx = 1'b1;
        state_nx     = RD_OUT;
      end
      RD_OUT: begin
        if (rd_hs) begin
          out_valid_nx = 1'b0;
          cnt_step     = 1'b1;
          if (cnt_last) begin
            state_nx = DONE;
          end else begin
            state_nx   = RD_ADDR;
            rf_addr_nx = next_addr;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rf_addr_q   <= '0;
      rf_din_q    <= '0;
      rf_wen_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nx;
      in_ready_q  <= in_ready_nx;
      out_valid_q <= out_valid_nx;
      out_data_q  <= out_data_nx;
      rf_addr_q   <= rf_addr_nx;
      rf_din_q    <= rf_din_nx;
      rf_wen_q    <= rf_wen_nx;
      busy_q      <= (state_nx != IDLE);
      done_q      <= (state_nx == DONE);
    end
  end

  assign strm.in_ready  = in_ready_q;
  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;
  assign rf_addr        = rf_addr_q;
  assign rf_din         = rf_din_q;
  assign rf_wen         = rf_wen_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign fsm_state      = state;
endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Bench for rf_seq_ctrl driving a real reg8: table of bursts plus a mid-write reset sequence.
module tb_rf_seq_ctrl;
  import rf_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start_wr, start_rd;
  logic [2:0] base_addr;
  logic [3:0] count;
  logic       busy, done;
  logic [2:0] rf_addr;
  logic [7:0] rf_din, rf_dout;
  logic       rf_wen;
  state_t     fsm_state;

  rf_seq_ctrl_if #(.DW(8)) strm ();

  rf_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_wr  (start_wr),
    .start_rd  (start_rd),
    .base_addr (base_addr),
    .count     (count),
    .strm      (strm),
    .busy      (busy),
    .done      (done),
    .rf_addr   (rf_addr),
    .rf_din    (rf_din),
    .rf_wen    (rf_wen),
    .rf_dout   (rf_dout),
    .fsm_state (fsm_state)
  );

  reg8 u_rf (
    .clk  (clk),
    .addr (rf_addr),
    .din  (rf_din),
    .wen  (rf_wen),
    .dout (rf_dout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int wen_cnt  = 0;

  logic [10:0] wr_exp_q[$];
  logic [7:0]  rd_exp_q[$];
  logic [7:0]  model [8];

  function automatic bit check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  // scoreboard: pops on every RF write and every read-stream beat
  always @(negedge clk) begin
    if (rst_n) begin
      if (rf_wen) begin
        wen_cnt++;
        if (wr_exp_q.size() == 0) void'(check("rf_wen_unexpected", 32'(rf_wen), 32'd0));
        else void'(check("rf_write_addr_data", 32'({rf_addr, rf_din}), 32'(wr_exp_q.pop_front())));
      end
      if (done) done_cnt++;
      if (strm.out_valid && strm.out_ready) begin
        if (rd_exp_q.size() == 0) void'(check("read_beat_unexpected", 32'(strm.out_valid), 32'd0));
        else void'(check("read_data", 32'(strm.out_data), 32'(rd_exp_q.pop_front())));
      end
    end
  end

  typedef struct {
    logic       wr;
    logic       both;
    logic [2:0] base;
    logic [3:0] cnt;
    logic [7:0] seed;
    int         gap;
    int         stall_beat;
    int         stall_len;
    int         exp_beats;
  } vec_t;

  vec_t vecs[13];

  // driver tasks
  task automatic start_burst(input logic wr, input logic rd, input logic [2:0] b, input logic [3:0] c);
    @(posedge clk); #1;
    start_wr = wr; start_rd = rd; base_addr = b; count = c;
    @(posedge clk); #1;
    start_wr = 1'b0; start_rd = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] b, input logic [7:0] seed, input int n, input int gap,
                          output int cyc);
    int t;
    logic [2:0] a;
    cyc = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        strm.in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; cyc++; end
      end
      strm.in_valid = 1'b1;
      strm.in_data  = seed + 8'(i);
      t = 0;
      while (!strm.in_ready && t < 20) begin @(posedge clk); #1; t++; cyc++; end
      if (!check("write_ready_timeout", 32'(strm.in_ready), 32'd1)) begin
        strm.in_valid = 1'b0;
        return;
      end
      a = 3'(b + 3'(i));
      wr_exp_q.push_back({a, seed + 8'(i)});
      model[a] = seed + 8'(i);
      @(posedge clk); #1; cyc++;
    end
    strm.in_valid = 1'b0;
  endtask

  task automatic do_read(input int n, input int stall_beat, input int stall_len);
    int t;
    logic [7:0] held;
    for (int i = 0; i < n; i++) begin
      strm.out_ready = (i == stall_beat) ? 1'b0 : 1'b1;
      t = 0;
      while (!strm.out_valid && t < 20) begin @(posedge clk); #1; t++; end
      if (!check("read_valid_timeout", 32'(strm.out_valid), 32'd1)) begin
        strm.out_ready = 1'b1;
        return;
      end
      void'(check("read_beat_latency", 32'(t), 32'd1));
      if (i == stall_beat) begin
        held = strm.out_data;
        repeat (stall_len) begin
          @(posedge clk); #1;
          void'(check("stall_valid_held", 32'(strm.out_valid), 32'd1));
          void'(check("stall_data_held", 32'(strm.out_data), 32'(held)));
        end
        strm.out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    strm.out_ready = 1'b1;
  endtask

  task automatic run_burst(input vec_t v);
    int d0, w0, cyc;
    d0 = done_cnt;
    w0 = wen_cnt;
    if (!v.wr)
      for (int i = 0; i < v.exp_beats; i++) rd_exp_q.push_back(model[3'(v.base + 3'(i))]);
    start_burst(v.wr, !v.wr || v.both, v.base, v.cnt);
    if (v.both) void'(check("both_starts_write", 32'(fsm_state), 32'(WRITE)));
    if (v.exp_beats == 0) begin
      void'(check("zero_len_rf_wen", 32'(rf_wen), 32'd0));
    end else if (v.wr) begin
      do_write(v.base, v.seed, v.exp_beats, v.gap, cyc);
      if (v.gap == 0) void'(check("write_full_rate_cycles", 32'(cyc), 32'(v.exp_beats)));
    end else begin
      do_read(v.exp_beats, v.stall_beat, v.stall_len);
    end
    void'(check("done_pulse", 32'(done), 32'd1));
    void'(check("busy_in_done", 32'(busy), 32'd1));
    @(posedge clk); #1;
    void'(check("done_cleared", 32'(done), 32'd0));
    void'(check("idle_not_busy", 32'(busy), 32'd0));
    void'(check("done_count", 32'(done_cnt - d0), 32'd1));
    void'(check("rf_wen_count", 32'(wen_cnt - w0), v.wr ? 32'(v.exp_beats) : 32'd0));
    void'(check("read_queue_drained", 32'(rd_exp_q.size()), 32'd0));
  endtask

  initial begin
    int d0, cyc;
    vec_t rv;
    start_wr = 1'b0; start_rd = 1'b0; base_addr = '0; count = '0;
    strm.in_valid = 1'b0; strm.in_data = '0; strm.out_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    void'(check("reset_outputs", 32'({strm.in_ready, strm.out_valid, strm.out_data, busy, done,
                                      rf_addr, rf_din, rf_wen}), 32'd0));
    void'(check("reset_state", 32'(fsm_state), 32'(IDLE)));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    //          wr    both  base  cnt    seed   gap stall len exp
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 4'd8,  8'h10, 0, -1, 0, 8};
    vecs[1]  = '{1'b0, 1'b0, 3'd0, 4'd8,  8'h00, 0, -1, 0, 8};
    vecs[2]  = '{1'b1, 1'b0, 3'd6, 4'd3,  8'hA0, 0, -1, 0, 3};
    vecs[3]  = '{1'b0, 1'b0, 3'd6, 4'd3,  8'h00, 0, -1, 0, 3};
    vecs[4]  = '{1'b0, 1'b0, 3'd0, 4'd8,  8'h00, 0,  1, 5, 8};
    vecs[5]  = '{1'b1, 1'b0, 3'd3, 4'd4,  8'h50, 2, -1, 0, 4};
    vecs[6]  = '{1'b0, 1'b0, 3'd2, 4'd4,  8'h00, 0, -1, 0, 4};
    vecs[7]  = '{1'b1, 1'b0, 3'd0, 4'd0,  8'h00, 0, -1, 0, 0};
    vecs[8]  = '{1'b0, 1'b0, 3'd5, 4'd0,  8'h00, 0, -1, 0, 0};
    vecs[9]  = '{1'b1, 1'b0, 3'd4, 4'd15, 8'(($urandom_range(0, 255))), 0, -1, 0, 8};
    vecs[10] = '{1'b0, 1'b0, 3'd4, 4'd15, 8'h00, 0, -1, 0, 8};
    vecs[11] = '{1'b1, 1'b1, 3'd1, 4'd2,  8'hE0, 0, -1, 0, 2};
    vecs[12] = '{1'b0, 1'b0, 3'd0, 4'd8,  8'h00, 0, -1, 0, 8};

    for (int k = 0; k < 13; k++) run_burst(vecs[k]);

    // reset after 2 of 4 write beats, once the second beat has reached the RF
    d0 = done_cnt;
    start_burst(1'b1, 1'b0, 3'd2, 4'd4);
    do_write(3'd2, 8'h70, 2, 0, cyc);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    void'(check("midwrite_reset_outputs", 32'({strm.in_ready, strm.out_valid, strm.out_data, busy,
                                               done, rf_addr, rf_din, rf_wen}), 32'd0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    void'(check("midwrite_no_done", 32'(done_cnt - d0), 32'd0));
    void'(check("midwrite_state_idle", 32'(fsm_state), 32'(IDLE)));
    void'(check("midwrite_wr_queue_empty", 32'(wr_exp_q.size()), 32'd0));
    rv = '{1'b0, 1'b0, 3'd2, 4'd3, 8'h00, 0, -1, 0, 3};
    run_burst(rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
